// File: rtl/spi_frame_sync_pkg.sv
// Shared types and defaults for the SPI frame synchronizer slice.
package spi_frame_sync_pkg;

    // Default width of one player word coming out of the SPI shifter.
    localparam int DEFAULT_WIDTH = 16;

    // Frame-tracking states of the load-strobe FSM.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOADING = 2'd1,
        SETTLE  = 2'd2,
        DRAIN   = 2'd3
    } spi_sync_state_t;

endpackage

// File: rtl/spi_frame_sync_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous control bit.
module spi_frame_sync_synchronizer
    import spi_frame_sync_pkg::*;
#(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the asynchronous input one stage deeper each clock.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    // Synchronizer chain, loaded with RESET_VAL on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_frame_sync.sv
// Moves the two SPI player words into the clk domain once the MCU load strobe
// has fallen and the shifter outputs have settled, then hands them to game
// logic through a valid/ready register with change, overrun and timeout flags.
module spi_frame_sync
    import spi_frame_sync_pkg::*;
#(
    parameter int WIDTH          = DEFAULT_WIDTH,
    parameter int SYNC_STAGES    = 2,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 2**20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] p1_raw,
    input  logic [WIDTH-1:0] p2_raw,
    output logic [WIDTH-1:0] p1,
    output logic [WIDTH-1:0] p2,
    output logic             valid,
    input  logic             ready,
    output logic             changed,
    output logic [7:0]       frame_count,
    output logic             overrun,
    output logic             timeout_err
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int ST_W = $clog2(SETTLE_CYCLES) + 1;

    logic                 load_s;
    logic                 rise;
    logic                 fall;
    logic                 capture;
    logic                 consume;
    logic [2*WIDTH-1:0]   compare_ref;

    spi_sync_state_t      state_q, state_d;
    logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
    logic [ST_W-1:0]      st_cnt_q, st_cnt_d;
    logic                 load_prev_q, load_prev_d;
    logic [WIDTH-1:0]     p1_q, p1_d;
    logic [WIDTH-1:0]     p2_q, p2_d;
    logic                 valid_q, valid_d;
    logic                 changed_q, changed_d;
    logic [7:0]           frame_count_q, frame_count_d;
    logic                 overrun_q, overrun_d;
    logic                 timeout_q, timeout_d;
    logic [2*WIDTH-1:0]   last_q, last_d;

    // The chain resets to 1 so that, together with the edge detector's
    // previous value resetting to 1, a strobe held high across reset never
    // shows up as a rising edge once the chain refills.
    spi_frame_sync_synchronizer #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_load_sync (
        .clk   (clk),
        .reset (reset),
        .d     (load),
        .q     (load_s)
    );

    assign rise = load_s & ~load_prev_q;
    assign fall = ~load_s & load_prev_q;

    // Frame FSM: track load, time out a stuck strobe, wait out the settle window.
    always_comb begin
        state_d     = state_q;
        to_cnt_d    = to_cnt_q;
        st_cnt_d    = st_cnt_q;
        timeout_d   = timeout_q;
        load_prev_d = load_s;
        capture     = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d  = LOADING;
                    to_cnt_d = '0;
                end else begin
                    state_d  = IDLE;
                end
            end
            LOADING: begin
                if (fall) begin
                    state_d  = SETTLE;
                    st_cnt_d = ST_W'(SETTLE_CYCLES - 1);
                end else if (load_s && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1))) begin
                    timeout_d = 1'b1;
                    state_d   = DRAIN;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            SETTLE: begin
                if (rise) begin
                    // A new frame started before sampling: drop this one.
                    state_d  = LOADING;
                    to_cnt_d = '0;
                end else if (st_cnt_q == ST_W'(0)) begin
                    capture = 1'b1;
                    state_d = IDLE;
                end else begin
                    st_cnt_d = st_cnt_q - ST_W'(1);
                end
            end
            DRAIN: begin
                if (fall) begin
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output register: capture new frames, retire accepted ones, flag overrun.
    always_comb begin
        consume       = valid_q & ready;
        p1_d          = p1_q;
        p2_d          = p2_q;
        valid_d       = valid_q;
        changed_d     = changed_q;
        frame_count_d = frame_count_q;
        overrun_d     = overrun_q;
        // A frame consumed this very cycle becomes the reference for changed.
        if (consume) begin
            compare_ref = {p1_q, p2_q};
            last_d      = {p1_q, p2_q};
        end else begin
            compare_ref = last_q;
            last_d      = last_q;
        end
        if (capture) begin
            p1_d          = p1_raw;
            p2_d          = p2_raw;
            valid_d       = 1'b1;
            changed_d     = ({p1_raw, p2_raw} != compare_ref);
            frame_count_d = frame_count_q + 8'd1;
            if (valid_q && !ready) begin
                overrun_d = 1'b1;
            end else begin
                overrun_d = overrun_q;
            end
        end else if (consume) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // All state and output flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            to_cnt_q      <= '0;
            st_cnt_q      <= '0;
            load_prev_q   <= 1'b1;
            p1_q          <= '0;
            p2_q          <= '0;
            valid_q       <= 1'b0;
            changed_q     <= 1'b0;
            frame_count_q <= 8'd0;
            overrun_q     <= 1'b0;
            timeout_q     <= 1'b0;
            last_q        <= '0;
        end else begin
            state_q       <= state_d;
            to_cnt_q      <= to_cnt_d;
            st_cnt_q      <= st_cnt_d;
            load_prev_q   <= load_prev_d;
            p1_q          <= p1_d;
            p2_q          <= p2_d;
            valid_q       <= valid_d;
            changed_q     <= changed_d;
            frame_count_q <= frame_count_d;
            overrun_q     <= overrun_d;
            timeout_q     <= timeout_d;
            last_q        <= last_d;
        end
    end

    assign p1          = p1_q;
    assign p2          = p2_q;
    assign valid       = valid_q;
    assign changed     = changed_q;
    assign frame_count = frame_count_q;
    assign overrun     = overrun_q;
    assign timeout_err = timeout_q;

endmodule
